// File: rtl/inst_dump_sequencer_if.sv
// inst_dump_sequencer_if
// Bundles the control, ROM and printer signals of the instruction dump
// sequencer. The sequencer connects through the master modport and the
// surrounding debug logic (ROM, printer, control) through the slave modport.
//
// Handshake: the sequencer holds `inst` stable and asserts `pulse` for exactly
// one cycle once it has seen `sink_ready` high while waiting. `sink_ready` is
// only sampled while the sequencer waits and never reaches an output
// combinationally. `rom_data` is expected in the same cycle as `rom_addr`.
interface inst_dump_sequencer_if;
   logic        start;
   logic        abort;
   logic [31:0] rom_addr;
   logic [31:0] rom_data;
   logic [31:0] inst;
   logic        pulse;
   logic        sink_ready;
   logic        busy;
   logic        done;
   logic [15:0] count;

   modport master (
      input  start, abort, rom_data, sink_ready,
      output rom_addr, inst, pulse, busy, done, count
   );

   modport slave (
      output start, abort, rom_data, sink_ready,
      input  rom_addr, inst, pulse, busy, done, count
   );
endinterface

// File: rtl/inst_dump_sequencer.sv
// inst_dump_sequencer
// Sweeps the ROM window START_ADDR..END_ADDR (inclusive, word steps), latches
// each fetched word and hands it to the instruction printer with a one-cycle
// pulse. Every output is a register, so start/sink_ready never reach an
// output combinationally. The FSM state is exposed on o_state for debug.
//
// Optional build macro: INST_DUMP_SKIP_NOP_EN -- when defined, all-zero ROM
// words are fetched but not printed (no wait, no pulse, no count increment).
module inst_dump_sequencer #(
   parameter logic [31:0] START_ADDR = 32'h00400000,
   parameter logic [31:0] END_ADDR   = 32'h00400074
) (
   input  logic                         clk,
   input  logic                         reset,
   inst_dump_sequencer_if.master        bus,
   output logic [2:0]                   o_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_WAIT  = 3'd2,
      S_PULSE = 3'd3,
      S_GAP   = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t      r_state;
   logic [31:0] r_rom_addr;
   logic [31:0] r_inst;
   logic        r_pulse;
   logic        r_busy;
   logic        r_done;
   logic [15:0] r_count;

   logic [15:0] w_count_inc;
   logic        w_last_word;

   // Saturating pulse counter increment and end-of-window detection.
   always_comb begin
      w_count_inc = (r_count == 16'hFFFF) ? r_count : r_count + 16'd1;
      w_last_word = (r_rom_addr == END_ADDR);
   end

   // Sequencer FSM; busy/done/pulse are registered alongside the state so
   // they always match the state being entered.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_rom_addr <= START_ADDR;
         r_inst     <= 32'h0;
         r_pulse    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_count    <= 16'h0;
      end else if (bus.abort) begin
         // Abort wins over everything, including start; count is kept so the
         // progress of the interrupted sweep stays visible.
         r_state    <= S_IDLE;
         r_rom_addr <= START_ADDR;
         r_pulse    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_count <= 16'h0;
                  r_busy  <= 1'b1;
                  r_state <= S_FETCH;
               end
            end

            S_FETCH: begin
               r_inst <= bus.rom_data;
`ifdef INST_DUMP_SKIP_NOP_EN
               if (bus.rom_data == 32'h0) begin
                  r_state <= S_GAP;
               end else begin
                  r_state <= S_WAIT;
               end
`else
               r_state <= S_WAIT;
`endif
            end

            S_WAIT: begin
               if (bus.sink_ready) begin
                  r_pulse <= 1'b1;
                  r_state <= S_PULSE;
               end
            end

            S_PULSE: begin
               r_pulse <= 1'b0;
               r_count <= w_count_inc;
               r_state <= S_GAP;
            end

            S_GAP: begin
               // Equality end test: the address never wraps past END_ADDR.
               if (w_last_word) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_rom_addr <= r_rom_addr + 32'd4;
                  r_state    <= S_FETCH;
               end
            end

            S_DONE: begin
               if (bus.start) begin
                  r_rom_addr <= START_ADDR;
                  r_count    <= 16'h0;
                  r_busy     <= 1'b1;
                  r_done     <= 1'b0;
                  r_state    <= S_FETCH;
               end
            end

            default: begin
               r_state    <= S_IDLE;
               r_rom_addr <= START_ADDR;
               r_pulse    <= 1'b0;
               r_busy     <= 1'b0;
               r_done     <= 1'b0;
            end
         endcase
      end
   end

   assign bus.rom_addr = r_rom_addr;
   assign bus.inst     = r_inst;
   assign bus.pulse    = r_pulse;
   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
   assign bus.count    = r_count;
   assign o_state      = r_state;

endmodule

// File: tb/tb_inst_dump_sequencer.sv
// tb_inst_dump_sequencer
// Random ROM contents and random sink_ready/start noise against a timeline
// model built from the sequencer's cycle rules (4 cycles per word, +1 per
// stalled WAIT cycle). A second instance covers the single-word window.
module tb_inst_dump_sequencer;

   localparam logic [31:0] START_A = 32'h00400000;
   localparam logic [31:0] END_A   = 32'h00400074;
   localparam logic [31:0] SINGLE  = 32'h00400010;
   localparam int          TL_MAX  = 512;
`ifdef INST_DUMP_SKIP_NOP_EN
   localparam int          NOP_PULSES = 29;
`else
   localparam int          NOP_PULSES = 30;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   inst_dump_sequencer_if bus_a ();
   inst_dump_sequencer_if bus_b ();
   logic [2:0] state_a;
   logic [2:0] state_b;

   logic [31:0] rom [64];
   assign bus_a.rom_data = rom[bus_a.rom_addr[7:2]];
   assign bus_b.rom_data = rom[bus_b.rom_addr[7:2]];

   inst_dump_sequencer dut_a (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus_a),
      .o_state (state_a)
   );

   inst_dump_sequencer #(
      .START_ADDR (SINGLE),
      .END_ADDR   (SINGLE)
   ) dut_b (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus_b),
      .o_state (state_b)
   );

   // ---------------- model: per-cycle timeline + expected print queue ----------------
   logic [31:0] tl_addr  [TL_MAX];
   logic [31:0] tl_inst  [TL_MAX];
   logic [15:0] tl_count [TL_MAX];
   bit          tl_busy  [TL_MAX];
   bit          tl_done  [TL_MAX];
   bit          tl_pulse [TL_MAX];
   bit          tl_inst_v[TL_MAX];
   bit          tl_ready [TL_MAX];
   bit          tl_start [TL_MAX];
   bit          tl_abort [TL_MAX];
   int          tl_len;

   logic [31:0] exp_q[$];

   int total = 0;
   int bad   = 0;
   int cur_off = 0;
   bit chk_en  = 1'b0;
   bit prev_pulse = 1'b0;
   int pulse_n = 0;
   int done_off = -1;
   int pulse_offs[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tl_set(input int o, input logic [31:0] a, input bit b, input bit d,
                         input bit p, input int c, input bit iv, input logic [31:0] iw);
      tl_addr[o]   = a;
      tl_busy[o]   = b;
      tl_done[o]   = d;
      tl_pulse[o]  = p;
      tl_count[o]  = 16'(c);
      tl_inst_v[o] = iv;
      tl_inst[o]   = iw;
      // start is only legal noise while busy; it must be ignored there
      tl_start[o]  = b ? 1'($urandom_range(0, 1)) : 1'b0;
   endtask

   // Offset 0 drives start; offset o>0 holds the outputs expected after o edges.
   task automatic build(input bit rand_stall, input int stall_word, input int stall_len,
                        input int abort_word);
      int t;
      int c;
      int k;
      int s;
      bit skip;
      logic [31:0] a;
      logic [31:0] w;
      logic [31:0] last_w;
      exp_q.delete();
      for (int o = 0; o < TL_MAX; o++) begin
         tl_ready[o]  = 1'($urandom_range(0, 1));
         tl_start[o]  = 1'b0;
         tl_abort[o]  = 1'b0;
         tl_inst_v[o] = 1'b0;
      end
      tl_start[0] = 1'b1;
      t = 1;
      c = 0;
      k = 0;
      a = START_A;
      last_w = 32'h0;
      forever begin
         w = rom[a[7:2]];
`ifdef INST_DUMP_SKIP_NOP_EN
         skip = (w == 32'h0);
`else
         skip = 1'b0;
`endif
         tl_set(t, a, 1'b1, 1'b0, 1'b0, c, 1'b0, 32'h0);
         if (skip) begin
            tl_set(t + 1, a, 1'b1, 1'b0, 1'b0, c, 1'b1, w);
            t += 2;
         end else begin
            if (k == stall_word) s = stall_len;
            else if (rand_stall) s = $urandom_range(0, 3);
            else s = 0;
            if (k == abort_word) s = 2;
            for (int j = 0; j <= s; j++) begin
               tl_set(t + 1 + j, a, 1'b1, 1'b0, 1'b0, c, 1'b1, w);
               tl_ready[t + 1 + j] = (j == s);
            end
            if (k == abort_word) begin
               tl_abort[t + 1] = 1'b1;
               for (int j = 2; j < 6; j++) tl_set(t + j, START_A, 1'b0, 1'b0, 1'b0, c, 1'b1, w);
               tl_len = t + 6;
               return;
            end
            tl_set(t + 2 + s, a, 1'b1, 1'b0, 1'b1, c, 1'b1, w);
            exp_q.push_back(w);
            tl_set(t + 3 + s, a, 1'b1, 1'b0, 1'b0, c + 1, 1'b1, w);
            c++;
            t += 4 + s;
         end
         last_w = w;
         k++;
         if (a == END_A) break;
         a += 32'd4;
      end
      for (int j = 0; j < 3; j++) tl_set(t + j, END_A, 1'b0, 1'b1, 1'b0, c, 1'b1, last_w);
      tl_len = t + 3;
   endtask

   // ---------------- driver ----------------
   task automatic run(input int stop_at);
      int n;
      n = (stop_at < tl_len) ? stop_at : tl_len;
      pulse_n  = 0;
      done_off = -1;
      pulse_offs.delete();
      for (int o = 0; o < n; o++) begin
         @(negedge clk);
         cur_off = o;
         chk_en  = (o > 0);
         bus_a.start      = tl_start[o];
         bus_a.abort      = tl_abort[o];
         bus_a.sink_ready = tl_ready[o];
      end
      if (n == tl_len) begin
         @(negedge clk);
         chk_en      = 1'b0;
         bus_a.start = 1'b0;
         bus_a.abort = 1'b0;
      end
   endtask

   // ---------------- compare process ----------------
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (chk_en) begin
            check($sformatf("addr@%0d", cur_off), bus_a.rom_addr, tl_addr[cur_off]);
            check($sformatf("busy@%0d", cur_off), {31'h0, bus_a.busy}, {31'h0, tl_busy[cur_off]});
            check($sformatf("done@%0d", cur_off), {31'h0, bus_a.done}, {31'h0, tl_done[cur_off]});
            check($sformatf("pulse@%0d", cur_off), {31'h0, bus_a.pulse}, {31'h0, tl_pulse[cur_off]});
            check($sformatf("count@%0d", cur_off), {16'h0, bus_a.count}, {16'h0, tl_count[cur_off]});
            if (tl_inst_v[cur_off])
               check($sformatf("inst@%0d", cur_off), bus_a.inst, tl_inst[cur_off]);
            check($sformatf("pulse_back2back@%0d", cur_off), {31'h0, prev_pulse & bus_a.pulse}, 32'h0);
            if (bus_a.pulse) begin
               pulse_n++;
               pulse_offs.push_back(cur_off);
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL pulse_extra@%0d: got inst %h expected no pulse", cur_off, bus_a.inst);
               end else begin
                  check($sformatf("print_inst@%0d", cur_off), bus_a.inst, exp_q.pop_front());
               end
            end
            if (bus_a.done && done_off < 0) done_off = cur_off;
         end
         prev_pulse = bus_a.pulse;
      end
   end

   // ---------------- main sequence ----------------
   int pulses_b;
   logic [31:0] inst_b;

   initial begin
      reset = 1'b0;
      bus_a.start = 1'b0; bus_a.abort = 1'b0; bus_a.sink_ready = 1'b0;
      bus_b.start = 1'b0; bus_b.abort = 1'b0; bus_b.sink_ready = 1'b1;
      for (int i = 0; i < 64; i++) rom[i] = $urandom;

      #12;
      check("rst_addr",  bus_a.rom_addr, START_A);
      check("rst_inst",  bus_a.inst, 32'h0);
      check("rst_pulse", {31'h0, bus_a.pulse}, 32'h0);
      check("rst_busy",  {31'h0, bus_a.busy}, 32'h0);
      check("rst_done",  {31'h0, bus_a.done}, 32'h0);
      check("rst_count", {16'h0, bus_a.count}, 32'h0);
      check("rst_addr_b", bus_b.rom_addr, SINGLE);
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // full sweep, no stalls
      build(1'b0, -1, 0, -1);
      run(TL_MAX);
      check("s1_pulses", pulse_n, 30);
      check("s1_done_off", done_off, 121);
      check("s1_pulse0_off", (pulse_offs.size() > 0) ? pulse_offs[0] : -1, 3);
      check("s1_pulse1_off", (pulse_offs.size() > 1) ? pulse_offs[1] : -1, 7);
      check("s1_count", {16'h0, bus_a.count}, 32'd30);
      check("s1_done", {31'h0, bus_a.done}, 32'h1);
      check("s1_left", exp_q.size(), 0);

      // 10-cycle stall on the third word
      build(1'b0, 2, 10, -1);
      run(TL_MAX);
      check("s2_pulse2_off", (pulse_offs.size() > 2) ? pulse_offs[2] : -1, 21);
      check("s2_pulses", pulse_n, 30);
      check("s2_left", exp_q.size(), 0);

      // abort in WAIT of the fifth word
      build(1'b1, -1, 0, 4);
      run(TL_MAX);
      check("s3_count", {16'h0, bus_a.count}, 32'd4);
      check("s3_addr", bus_a.rom_addr, START_A);
      check("s3_busy", {31'h0, bus_a.busy}, 32'h0);
      check("s3_pulses", pulse_n, 4);

      // restart after abort with random stalls
      build(1'b1, -1, 0, -1);
      run(TL_MAX);
      check("s4_pulses", pulse_n, 30);
      check("s4_left", exp_q.size(), 0);

      // all-zero word at 0x00400008
      rom[2] = 32'h0;
      build(1'b1, -1, 0, -1);
      run(TL_MAX);
      check("s5_pulses", pulse_n, NOP_PULSES);
      check("s5_left", exp_q.size(), 0);

      // reset during the first PULSE
      build(1'b0, -1, 0, -1);
      run(4);
      chk_en = 1'b0;
      #2;
      check("pre_reset_pulse", {31'h0, bus_a.pulse}, 32'h1);
      reset = 1'b0;
      #1;
      check("arst_pulse", {31'h0, bus_a.pulse}, 32'h0);
      check("arst_addr",  bus_a.rom_addr, START_A);
      check("arst_inst",  bus_a.inst, 32'h0);
      check("arst_busy",  {31'h0, bus_a.busy}, 32'h0);
      check("arst_count", {16'h0, bus_a.count}, 32'h0);
      bus_a.start = 1'b0; bus_a.abort = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // single-word window
      bus_b.start = 1'b1;
      @(negedge clk);
      bus_b.start = 1'b0;
      pulses_b = 0;
      inst_b = 32'h0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         #1;
         if (bus_b.pulse) begin
            pulses_b++;
            inst_b = bus_b.inst;
         end
      end
      check("b_pulses", pulses_b, 1);
      check("b_inst", inst_b, rom[4]);
      check("b_done", {31'h0, bus_b.done}, 32'h1);
      check("b_count", {16'h0, bus_b.count}, 32'h1);
      check("b_addr", bus_b.rom_addr, SINGLE);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
